// File: rtl/calc_key_seq.sv
// rtl/calc_key_seq.sv - keypad add/sub sequencer driving a downstream add/sub controller
// Optional build macro: CALC_WAIT_TIMEOUT_EN (WAIT-state timeout to ERR after TIMEOUT cycles).
module calc_key_seq #(
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         done,
    input  logic         v_,
    output logic         ad,
    output logic         su,
    output logic [W-1:0] x_opnd,
    output logic [W-1:0] y_opnd,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {S_X, S_Y, S_GO, S_WAIT, S_ERR} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   x_nxt;
    logic [W-1:0]   y_nxt;
    logic           op;
    logic           op_nxt;
    logic           is_digit;
    logic           is_add;
    logic           is_sub;
    logic           is_eq;
    logic           is_clr;
    logic [W-1:0]   active;
    logic [W+3:0]   cand;
    logic           fits;
    logic           timeout_hit;

    generate
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("TIMEOUT must be at least 1");
        end
    endgenerate

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_add   = key_valid && (key_code == 4'd10);
    assign is_sub   = key_valid && (key_code == 4'd11);
    assign is_eq    = key_valid && (key_code == 4'd12);
    assign is_clr   = key_valid && (key_code == 4'd13);

    // Candidate operand*10+d computed 4 bits wider so an out-of-range entry is detected, not wrapped.
    assign active = (state == S_Y) ? y_opnd : x_opnd;
    assign cand   = ({4'b0000, active} * (W+4)'(10)) + {{W{1'b0}}, key_code};
    assign fits   = (cand <= {4'b0000, {W{1'b1}}});

`ifdef CALC_WAIT_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state != S_WAIT) begin
            cnt <= '0;
        end else if (!done) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout_hit = (cnt == LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        x_nxt     = x_opnd;
        y_nxt     = y_opnd;
        op_nxt    = op;
        case (state)
            S_X: begin
                if (is_digit && fits) begin
                    x_nxt = cand[W-1:0];
                end else if (is_add || is_sub) begin
                    op_nxt    = is_sub;
                    state_nxt = S_Y;
                end else if (is_clr) begin
                    x_nxt  = '0;
                    y_nxt  = '0;
                    op_nxt = 1'b0;
                end
            end
            S_Y: begin
                if (is_digit && fits) begin
                    y_nxt = cand[W-1:0];
                end else if (is_add || is_sub) begin
                    op_nxt = is_sub;
                end else if (is_eq) begin
                    state_nxt = S_GO;
                end else if (is_clr) begin
                    x_nxt     = '0;
                    y_nxt     = '0;
                    op_nxt    = 1'b0;
                    state_nxt = S_X;
                end
            end
            S_GO: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Abort has priority over a completion arriving in the same cycle.
                if (is_clr || (done && !v_)) begin
                    x_nxt     = '0;
                    y_nxt     = '0;
                    op_nxt    = 1'b0;
                    state_nxt = S_X;
                end else if (done || timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                if (is_clr) begin
                    x_nxt     = '0;
                    y_nxt     = '0;
                    op_nxt    = 1'b0;
                    state_nxt = S_X;
                end
            end
            default: begin
                state_nxt = S_X;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_X;
            x_opnd <= '0;
            y_opnd <= '0;
            op     <= 1'b0;
            ad     <= 1'b0;
            su     <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            x_opnd <= x_nxt;
            y_opnd <= y_nxt;
            op     <= op_nxt;
            ad     <= (state_nxt == S_GO) && !op_nxt;
            su     <= (state_nxt == S_GO) && op_nxt;
            busy   <= (state_nxt == S_GO) || (state_nxt == S_WAIT);
            err    <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_calc_key_seq.sv
// tb/tb_calc_key_seq.sv - randomized and directed bench for calc_key_seq against a behavioural model
module tb_calc_key_seq;

    localparam int W       = 8;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         done;
    logic         v_;
    logic         ad;
    logic         su;
    logic [W-1:0] x_opnd;
    logic [W-1:0] y_opnd;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    // 0 entering x, 1 entering y, 2 issuing, 3 waiting, 4 error
    int m_mode;
    int m_x;
    int m_y;
    bit m_sub;
    int m_waited;

    always #5 clk = ~clk;

    calc_key_seq #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .done      (done),
        .v_        (v_),
        .ad        (ad),
        .su        (su),
        .x_opnd    (x_opnd),
        .y_opnd    (y_opnd),
        .busy      (busy),
        .err       (err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int grow(input int v, input int d);
        return (v * 10 + d <= (1 << W) - 1) ? v * 10 + d : v;
    endfunction

    task automatic model_clear();
        m_mode = 0;
        m_x    = 0;
        m_y    = 0;
        m_sub  = 1'b0;
    endtask

    task automatic model_apply(input bit kv, input int kc, input bit dn, input bit vv);
        int key;
        key = kv ? kc : 15;
        case (m_mode)
            0: begin
                if (key <= 9) m_x = grow(m_x, key);
                else if (key == 10 || key == 11) begin m_sub = (key == 11); m_mode = 1; end
                else if (key == 13) model_clear();
            end
            1: begin
                if (key <= 9) m_y = grow(m_y, key);
                else if (key == 10 || key == 11) m_sub = (key == 11);
                else if (key == 12) m_mode = 2;
                else if (key == 13) model_clear();
            end
            2: begin
                m_mode   = 3;
                m_waited = 0;
            end
            3: begin
                if (key == 13) model_clear();
                else if (dn && vv) m_mode = 4;
                else if (dn) model_clear();
                else begin
                    m_waited++;
`ifdef CALC_WAIT_TIMEOUT_EN
                    if (m_waited == TIMEOUT) m_mode = 4;
`endif
                end
            end
            default: begin
                if (key == 13) model_clear();
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".x"}, 32'(x_opnd), m_x);
        check_val({tag, ".y"}, 32'(y_opnd), m_y);
        check_val({tag, ".ad"}, 32'(ad), (m_mode == 2 && !m_sub) ? 1 : 0);
        check_val({tag, ".su"}, 32'(su), (m_mode == 2 && m_sub) ? 1 : 0);
        check_val({tag, ".busy"}, 32'(busy), (m_mode == 2 || m_mode == 3) ? 1 : 0);
        check_val({tag, ".err"}, 32'(err), (m_mode == 4) ? 1 : 0);
    endtask

    // Called at a falling edge: drive, clock, update model, compare just after the rising edge.
    task automatic cycle(input bit kv, input int kc, input bit dn, input bit vv, input string tag);
        key_valid = kv;
        key_code  = 4'(kc);
        done      = dn;
        v_        = vv;
        @(posedge clk);
        model_apply(kv, kc, dn, vv);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic press(input int kc, input string tag);
        cycle(1'b1, kc, 1'b0, 1'b0, tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        done      = 1'b0;
        v_        = 1'b0;
        model_clear();
        m_waited  = 0;
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // 12 + 3, done arriving during GO is ignored
        press(1, "add"); press(2, "add"); press(10, "add"); press(3, "add");
        check_val("add_x12", 32'(x_opnd), 12);
        check_val("add_y3", 32'(y_opnd), 3);
        press(12, "add_eq");
        check_val("add_ad_pulse", 32'(ad), 1);
        check_val("add_su_low", 32'(su), 0);
        cycle(1'b0, 0, 1'b1, 1'b1, "add_go_done_ignored");
        check_val("add_ad_one_cycle", 32'(ad), 0);
        cycle(1'b0, 0, 1'b1, 1'b0, "add_done");
        check_val("add_done_x0", 32'(x_opnd), 0);
        check_val("add_done_busy0", 32'(busy), 0);

        // overflow of the operand entry is rejected without wrap
        press(2, "ovf"); press(5, "ovf"); press(5, "ovf"); press(7, "ovf");
        check_val("ovf_x255", 32'(x_opnd), 255);
        press(13, "ovf_clr");
        press(2, "ovf2"); press(5, "ovf2"); press(6, "ovf2");
        check_val("ovf_x25", 32'(x_opnd), 25);
        press(13, "ovf2_clr");

        // subtract with overflow result -> ERR, frozen, cleared by C
        press(9, "sub"); press(11, "sub"); press(9, "sub"); press(10, "sub"); press(11, "sub");
        press(12, "sub_eq");
        check_val("sub_su_pulse", 32'(su), 1);
        check_val("sub_ad_low", 32'(ad), 0);
        idle("sub_go");
        cycle(1'b0, 0, 1'b1, 1'b1, "sub_ovf");
        check_val("sub_err", 32'(err), 1);
        press(5, "err_digit");
        check_val("err_x_frozen", 32'(x_opnd), 9);
        press(13, "err_clr");
        check_val("err_cleared", 32'(err), 0);

        // C and done together in WAIT
        press(1, "cd"); press(10, "cd"); press(2, "cd"); press(12, "cd"); idle("cd_go");
        cycle(1'b1, 13, 1'b1, 1'b1, "cd_same");
        check_val("cd_err0", 32'(err), 0);
        check_val("cd_busy0", 32'(busy), 0);

        // long wait without done
        press(3, "to"); press(10, "to"); press(4, "to"); press(12, "to"); idle("to_go");
        for (int i = 0; i < 100; i++) begin
            idle("to_wait");
`ifdef CALC_WAIT_TIMEOUT_EN
            check_val("to_err", 32'(err), (i >= TIMEOUT - 1) ? 1 : 0);
`else
            check_val("to_busy", 32'(busy), 1);
`endif
        end
        press(13, "to_clr");

        // asynchronous reset in the middle of WAIT
        press(1, "ar"); press(10, "ar"); press(1, "ar"); press(12, "ar"); idle("ar_go");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        check_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 0, 1'b1, 1'b0, "after_rst");
            check_val("after_rst_no_pulse", 32'(ad | su), 0);
        end

        // random key/done traffic
        for (int i = 0; i < 3000; i++) begin
            bit kv;
            int kc;
            bit dn;
            bit vv;
            kv = ($urandom_range(0, 2) != 0);
            kc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            dn = ($urandom_range(0, 5) == 0);
            vv = ($urandom_range(0, 3) == 0);
            cycle(kv, kc, dn, vv, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
